// File: rtl/seq_mult_param_pkg.sv
// Shared definitions for the time-shared digit multiplier: FSM encoding and counter sizing.
package seq_mult_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FIX  = 3'd2,
    ST_DONE = 3'd3
  } state_e;

  // Counter width needed to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the shared digit multiplier: walks every (i, j) digit pair once, then sign fix and done.
module seq_mult_ctrl
  import seq_mult_param_pkg::*;
#(
  parameter int ND = 4,
  parameter int IW = cnt_width(ND)
) (
  input  logic          clk,
  input  logic          reset_a,
  input  logic          start,
  output logic [IW-1:0] i_sel,
  output logic [IW-1:0] j_sel,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          fix_en,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_out
);

  localparam logic [IW-1:0] LAST = IW'(ND - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic          busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          i_d     = '0;
          j_d     = '0;
        end
      end
      ST_CALC: begin
        // j is the fast index, so step k maps to i = k / ND, j = k % ND.
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) state_d = ST_FIX;
          else             i_d     = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign i_sel     = i_q;
  assign j_sel     = j_q;
  assign acc_clr   = (state_q == ST_IDLE) && start;
  assign acc_en    = (state_q == ST_CALC);
  assign fix_en    = (state_q == ST_FIX);
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = state_q;

endmodule

// File: rtl/seq_mult_param.sv
// WIDTH x WIDTH sequential multiplier built on one DIGIT x DIGIT multiplier, one partial product per clock.
// Signed operands are multiplied as magnitudes and the sign is applied once at the end.
module seq_mult_param
  import seq_mult_param_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [2:0]         state_out
);

  localparam int ND = WIDTH / DIGIT;
  localparam int IW = cnt_width(ND);
  localparam int PW = 2 * WIDTH;

  logic [IW-1:0]      i_sel, j_sel;
  logic               acc_clr, acc_en, fix_en;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               neg_q, neg_d;
  logic [PW-1:0]      acc_q, acc_d, product_q, product_d;
  logic               sa, sb;
  logic [DIGIT-1:0]   a_dig, b_dig;
  logic [2*DIGIT-1:0] pp;
  logic [PW-1:0]      pp_shift;

  seq_mult_ctrl #(.ND(ND), .IW(IW)) u_ctrl (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start),
    .i_sel     (i_sel),
    .j_sel     (j_sel),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .fix_en    (fix_en),
    .busy      (busy),
    .done      (done),
    .state_out (state_out)
  );

  always_comb begin
    sa = dataa[WIDTH-1] & signed_mode;
    sb = datab[WIDTH-1] & signed_mode;
    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    a_d   = acc_clr ? (sa ? -dataa : dataa) : a_q;
    b_d   = acc_clr ? (sb ? -datab : datab) : b_q;
    neg_d = acc_clr ? (sa ^ sb) : neg_q;

    a_dig    = DIGIT'(a_q >> (DIGIT * int'(i_sel)));
    b_dig    = DIGIT'(b_q >> (DIGIT * int'(j_sel)));
    pp       = {{DIGIT{1'b0}}, a_dig} * {{DIGIT{1'b0}}, b_dig};
    pp_shift = PW'(pp) << (DIGIT * (int'(i_sel) + int'(j_sel)));

    acc_d = acc_q;
    if (acc_clr)     acc_d = '0;
    else if (acc_en) acc_d = acc_q + pp_shift;

    product_d = fix_en ? (neg_q ? -acc_q : acc_q) : product_q;
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
